// File: rtl/booth_arb_pkg.sv
// Shared types and helpers for the round-robin Booth multiplier arbiter.
package booth_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int DEF_N    = 8;
  localparam int DEF_NREQ = 4;

  // Index of the requester after idx, wrapping at nreq.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned nreq);
    return (idx + 1 >= nreq) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first request at or after rr_ptr, scanning upward with wrap.
module rr_arbiter
  import booth_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] win_onehot,
  output logic [IDW-1:0]  win_idx,
  output logic            win_any
);

  logic [IDW-1:0] cand;
  logic           found;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    found      = 1'b0;
    cand       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IDW'((32'(rr_ptr) + i) % 32'(NREQ));
      if (!found && req[cand]) begin
        found            = 1'b1;
        win_onehot[cand] = 1'b1;
        win_idx          = cand;
      end
    end
  end

  assign win_any = |req;

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin sharing of one sequential Booth multiplier among NREQ requesters.
// Optional macro BOOTH_ARB_TIMEOUT_EN adds a mul_done watchdog that reports rsp_err.
module booth_mul_arbiter
  import booth_arb_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int NREQ    = DEF_NREQ,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] req_m,
  input  logic [NREQ*N-1:0] req_q,
  output logic [NREQ-1:0]   grant,
  output logic [N-1:0]      mul_m,
  output logic [N-1:0]      mul_q,
  output logic              mul_start,
  input  logic              mul_done,
  input  logic [2*N-1:0]    mul_product,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*N-1:0]    rsp_product,
  output logic              rsp_err,
  output logic              busy
);

  if ((2**IDW) < NREQ || NREQ < 2 || TIMEOUT < 1) begin : g_param_check
    $error("booth_mul_arbiter: invalid parameter combination");
  end

  arb_state_t state, state_n;
  logic [IDW-1:0]  rr_ptr;
  logic [NREQ-1:0] win_onehot;
  logic [IDW-1:0]  win_idx;
  logic            win_any;
  logic            to_hit;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req        (req),
    .rr_ptr     (rr_ptr),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .win_any    (win_any)
  );

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
  logic          rsp_err_q;

  // Fires on the TIMEOUT-th consecutive WAIT cycle without mul_done.
  assign to_hit  = (state == WAIT) && (to_cnt == TW'(TIMEOUT - 1));
  assign rsp_err = rsp_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt    <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state == ISSUE)
        to_cnt <= '0;
      else if (state == WAIT)
        to_cnt <= to_cnt + 1'b1;
      if (state == IDLE && win_any)
        rsp_err_q <= 1'b0;
      else if (state == WAIT && !mul_done && to_hit)
        rsp_err_q <= 1'b1;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (win_any) state_n = ISSUE;
      ISSUE:   state_n = WAIT;
      WAIT:    if (mul_done || to_hit) state_n = RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // mul_start is registered off ISSUE so it lands one cycle after grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant       <= '0;
      mul_m       <= '0;
      mul_q       <= '0;
      mul_start   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
      rr_ptr      <= '0;
    end else begin
      grant     <= '0;
      mul_start <= (state == ISSUE);
      case (state)
        IDLE: begin
          if (win_any) begin
            grant  <= win_onehot;
            mul_m  <= req_m[win_idx*N +: N];
            mul_q  <= req_q[win_idx*N +: N];
            rsp_id <= win_idx;
          end
        end
        WAIT: begin
          if (mul_done)
            rsp_product <= mul_product;
          else if (to_hit)
            rsp_product <= '0;
        end
        RESP: begin
          if (rsp_ready)
            rr_ptr <= IDW'(rr_next(32'(rsp_id), NREQ));
        end
        default: ;
      endcase
    end
  end

endmodule
